// File: rtl/turn_sequencer.sv
// turn_sequencer
// ------------------------------------------------------------------------
// Turn scheduler for the two-player board game. Accepts one dice roll per
// turn for the active player, moves that player's piece (clamped at the
// goal tile), publishes the new target x coordinate with a one-cycle
// pos_valid pulse, waits for the renderer's turn_done (bounded by a
// timeout), applies the question-box bonus move, and then either hands the
// turn to the other player or declares a winner.
//
// Ports
//   clk            system clock (shared with ui_render)
//   rst            synchronous, active-high reset
//   roll_valid     a dice roll is offered
//   roll_value     roll value, legal range 1..6
//   roll_ready     roll is accepted this cycle if roll_valid (IDLE only)
//   turn_done      one-cycle pulse from the renderer: movement finished
//   player1_pos_x  target x coordinate of player 1
//   player2_pos_x  target x coordinate of player 2
//   pos_valid      one-cycle pulse: targets were just updated
//   active_player  0 = player 1, 1 = player 2
//   p1_tile        player 1 tile index
//   p2_tile        player 2 tile index
//   game_over      sticky: a player reached the goal tile
//   winner         winning player, meaningful while game_over
//   timeout_err    sticky: a turn_done wait expired
// ------------------------------------------------------------------------
module turn_sequencer #(
  parameter int NUM_TILES    = 10,
  parameter int TILE_X0      = 20,
  parameter int TILE_W       = 60,
  parameter int QBOX_TILE    = 4,
  parameter int QBOX_BONUS   = 2,
  parameter int DONE_TIMEOUT = 4_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       roll_valid,
  input  logic [2:0] roll_value,
  output logic       roll_ready,
  input  logic       turn_done,
  output logic [9:0] player1_pos_x,
  output logic [9:0] player2_pos_x,
  output logic       pos_valid,
  output logic       active_player,
  output logic [3:0] p1_tile,
  output logic [3:0] p2_tile,
  output logic       game_over,
  output logic       winner,
  output logic       timeout_err
);

  localparam logic [3:0]  GOAL         = 4'(NUM_TILES - 1);
  localparam logic [3:0]  QBOX         = 4'(QBOX_TILE);
  localparam logic [4:0]  BONUS_STEP   = 5'(QBOX_BONUS);
  localparam logic [23:0] TIMEOUT_LAST = 24'(DONE_TIMEOUT - 1);
  localparam logic [9:0]  X_RESET      = 10'(TILE_X0);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    BONUS,
    FINISH
  } state_t;

  state_t      state, state_next;
  logic [3:0]  p1_tile_next, p2_tile_next;
  logic [9:0]  p1_x_next, p2_x_next;
  logic        pos_valid_next;
  logic        active_next;
  logic        game_over_next;
  logic        winner_next;
  logic        timeout_err_next;
  logic        bonus_move, bonus_move_next;
  logic [23:0] wait_cnt, wait_cnt_next;

  logic [3:0]  cur_tile;
  logic [3:0]  new_tile;
  logic        load_tile;
  logic        roll_legal;
  logic        move_finished;

  // x coordinate of a tile; widened before truncation so the product
  // never wraps before the final 10-bit cut.
  function automatic logic [9:0] tile_to_x(input logic [3:0] tile);
    logic [13:0] x_wide;
    x_wide = 14'(TILE_X0) + 14'(tile) * 14'(TILE_W);
    return x_wide[9:0];
  endfunction

  // Step a piece forward, stopping at the goal tile.
  function automatic logic [3:0] advance(input logic [3:0] tile,
                                         input logic [4:0] step);
    logic [4:0] sum;
    sum = {1'b0, tile} + step;
    return (sum > {1'b0, GOAL}) ? GOAL : sum[3:0];
  endfunction

  assign roll_ready    = (state == IDLE);
  assign cur_tile      = active_player ? p2_tile : p1_tile;
  assign roll_legal    = (roll_value != 3'd0) && (roll_value != 3'd7);
  assign move_finished = turn_done || (wait_cnt == TIMEOUT_LAST);

  // State and datapath registers. Every output except roll_ready is
  // registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      p1_tile       <= 4'd0;
      p2_tile       <= 4'd0;
      player1_pos_x <= X_RESET;
      player2_pos_x <= X_RESET;
      pos_valid     <= 1'b0;
      active_player <= 1'b0;
      game_over     <= 1'b0;
      winner        <= 1'b0;
      timeout_err   <= 1'b0;
      bonus_move    <= 1'b0;
      wait_cnt      <= 24'd0;
    end else begin
      state         <= state_next;
      p1_tile       <= p1_tile_next;
      p2_tile       <= p2_tile_next;
      player1_pos_x <= p1_x_next;
      player2_pos_x <= p2_x_next;
      pos_valid     <= pos_valid_next;
      active_player <= active_next;
      game_over     <= game_over_next;
      winner        <= winner_next;
      timeout_err   <= timeout_err_next;
      bonus_move    <= bonus_move_next;
      wait_cnt      <= wait_cnt_next;
    end
  end

  // Next-state and datapath decisions. A move (roll or bonus) only ever
  // touches the active player's tile and x, which is why the write-back is
  // factored out after the case statement.
  always_comb begin
    state_next       = state;
    p1_tile_next     = p1_tile;
    p2_tile_next     = p2_tile;
    p1_x_next        = player1_pos_x;
    p2_x_next        = player2_pos_x;
    pos_valid_next   = 1'b0;
    active_next      = active_player;
    game_over_next   = game_over;
    winner_next      = winner;
    timeout_err_next = timeout_err;
    bonus_move_next  = bonus_move;
    wait_cnt_next    = wait_cnt;
    new_tile         = cur_tile;
    load_tile        = 1'b0;

    case (state)
      IDLE: begin
        if (roll_valid && roll_legal) begin
          new_tile        = advance(cur_tile, {2'b00, roll_value});
          load_tile       = 1'b1;
          pos_valid_next  = 1'b1;
          bonus_move_next = 1'b0;
          state_next      = ISSUE;
        end
      end

      ISSUE: begin
        wait_cnt_next = 24'd0;
        state_next    = WAIT_DONE;
      end

      WAIT_DONE: begin
        wait_cnt_next = wait_cnt + 24'd1;
        if (move_finished) begin
          // A done arriving on the expiry cycle is a normal completion.
          if (!turn_done) begin
            timeout_err_next = 1'b1;
          end
          if (cur_tile == GOAL) begin
            game_over_next = 1'b1;
            winner_next    = active_player;
            state_next     = FINISH;
          end else if (!bonus_move && (cur_tile == QBOX)) begin
            new_tile       = advance(cur_tile, BONUS_STEP);
            load_tile      = 1'b1;
            pos_valid_next = 1'b1;
            state_next     = BONUS;
          end else begin
            active_next = ~active_player;
            state_next  = IDLE;
          end
        end
      end

      BONUS: begin
        wait_cnt_next   = 24'd0;
        bonus_move_next = 1'b1;
        state_next      = WAIT_DONE;
      end

      FINISH: begin
        state_next = FINISH;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    if (load_tile) begin
      if (active_player) begin
        p2_tile_next = new_tile;
        p2_x_next    = tile_to_x(new_tile);
      end else begin
        p1_tile_next = new_tile;
        p1_x_next    = tile_to_x(new_tile);
      end
    end
  end

endmodule

// File: tb/tb_turn_sequencer.sv
// tb_turn_sequencer
// ------------------------------------------------------------------------
// Self-checking bench for turn_sequencer. Directed scenarios cover reset,
// a basic turn, the question-box bonus, the goal, ignored inputs, the
// done timeout and a mid-turn reset; randomized games are then checked
// against a small game model (tile positions, whose turn it is, winner).
// The DUT runs with a short turn_done timeout so expiry is reachable.
// ------------------------------------------------------------------------
module tb_turn_sequencer;

  localparam int NUM_TILES  = 10;
  localparam int GOAL       = NUM_TILES - 1;
  localparam int TILE_X0    = 20;
  localparam int TILE_W     = 60;
  localparam int QBOX_TILE  = 4;
  localparam int QBOX_BONUS = 2;
  localparam int T_OUT      = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       roll_valid;
  logic [2:0] roll_value;
  logic       roll_ready;
  logic       turn_done;
  logic [9:0] player1_pos_x;
  logic [9:0] player2_pos_x;
  logic       pos_valid;
  logic       active_player;
  logic [3:0] p1_tile;
  logic [3:0] p2_tile;
  logic       game_over;
  logic       winner;
  logic       timeout_err;

  int tests_run    = 0;
  int tests_failed = 0;

  // Game model: where each piece stands and whose turn it is.
  int m_tile[2];
  int m_active;
  bit m_over;
  int m_winner;
  bit m_terr;

  turn_sequencer #(
    .NUM_TILES   (NUM_TILES),
    .TILE_X0     (TILE_X0),
    .TILE_W      (TILE_W),
    .QBOX_TILE   (QBOX_TILE),
    .QBOX_BONUS  (QBOX_BONUS),
    .DONE_TIMEOUT(T_OUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .roll_valid   (roll_valid),
    .roll_value   (roll_value),
    .roll_ready   (roll_ready),
    .turn_done    (turn_done),
    .player1_pos_x(player1_pos_x),
    .player2_pos_x(player2_pos_x),
    .pos_valid    (pos_valid),
    .active_player(active_player),
    .p1_tile      (p1_tile),
    .p2_tile      (p2_tile),
    .game_over    (game_over),
    .winner       (winner),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  function automatic int model_x(input int tile);
    return TILE_X0 + tile * TILE_W;
  endfunction

  function automatic int model_move(input int tile, input int steps);
    return (tile + steps > GOAL) ? GOAL : tile + steps;
  endfunction

  task automatic model_reset();
    m_tile[0] = 0;
    m_tile[1] = 0;
    m_active  = 0;
    m_over    = 1'b0;
    m_winner  = 0;
    m_terr    = 1'b0;
  endtask

  // Stimulus helpers: inputs change on the falling edge, outputs are
  // observed on the falling edge as well.
  task automatic do_reset();
    rst        = 1'b1;
    roll_valid = 1'b0;
    roll_value = 3'd0;
    turn_done  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic offer_roll(input int v);
    roll_valid = 1'b1;
    roll_value = 3'(v);
    @(negedge clk);
    roll_valid = 1'b0;
  endtask

  task automatic pulse_done();
    turn_done = 1'b1;
    @(negedge clk);
    turn_done = 1'b0;
  endtask

  // A plain turn with no bonus: roll, done on the first wait cycle.
  task automatic quick_turn(input int v);
    offer_roll(v);
    @(negedge clk);
    pulse_done();
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    roll_valid = 1'b1;
    roll_value = 3'd3;
    turn_done  = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({player1_pos_x, player2_pos_x} !== {10'(TILE_X0), 10'(TILE_X0)}) begin
      tests_failed++;
      $display("[TB] FAIL reset_pos_x: got p1=%0d p2=%0d expected %0d",
               player1_pos_x, player2_pos_x, TILE_X0);
    end
    tests_run++;
    if ({p1_tile, p2_tile} !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL reset_tiles: got p1=%0d p2=%0d expected 0", p1_tile, p2_tile);
    end
    tests_run++;
    if ({pos_valid, active_player, roll_ready, game_over, winner, timeout_err} !== 6'b001000) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags: got %b expected 001000",
               {pos_valid, active_player, roll_ready, game_over, winner, timeout_err});
    end
    rst        = 1'b0;
    roll_valid = 1'b0;
    turn_done  = 1'b0;
    model_reset();
  endtask

  task automatic test_basic_turn();
    int extra_pulses;
    do_reset();
    offer_roll(3);
    tests_run++;
    if (pos_valid !== 1'b1 || player1_pos_x !== 10'(model_x(3)) || p1_tile !== 4'd3) begin
      tests_failed++;
      $display("[TB] FAIL basic_issue: got pv=%b x=%0d tile=%0d expected pv=1 x=%0d tile=3",
               pos_valid, player1_pos_x, p1_tile, model_x(3));
    end
    tests_run++;
    if (player2_pos_x !== 10'(TILE_X0) || active_player !== 1'b0 || roll_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL basic_other: got p2x=%0d act=%b rdy=%b expected 20 0 0",
               player2_pos_x, active_player, roll_ready);
    end
    extra_pulses = 0;
    repeat (5) begin
      @(negedge clk);
      if (pos_valid !== 1'b0) extra_pulses++;
    end
    pulse_done();
    tests_run++;
    if (extra_pulses != 0) begin
      tests_failed++;
      $display("[TB] FAIL basic_single_pulse: got %0d extra pulses expected 0", extra_pulses);
    end
    tests_run++;
    if (active_player !== 1'b1 || roll_ready !== 1'b1 || pos_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL basic_handover: got act=%b rdy=%b pv=%b expected 1 1 0",
               active_player, roll_ready, pos_valid);
    end
    tests_run++;
    if (player2_pos_x !== 10'(TILE_X0) || player1_pos_x !== 10'(model_x(3))) begin
      tests_failed++;
      $display("[TB] FAIL basic_hold_x: got p1x=%0d p2x=%0d expected %0d 20",
               player1_pos_x, player2_pos_x, model_x(3));
    end
  endtask

  task automatic test_qbox();
    do_reset();
    offer_roll(4);
    tests_run++;
    if (pos_valid !== 1'b1 || player1_pos_x !== 10'(model_x(4)) || p1_tile !== 4'(QBOX_TILE)) begin
      tests_failed++;
      $display("[TB] FAIL qbox_land: got pv=%b x=%0d tile=%0d expected pv=1 x=%0d tile=4",
               pos_valid, player1_pos_x, p1_tile, model_x(4));
    end
    repeat (2) @(negedge clk);
    pulse_done();
    tests_run++;
    if (pos_valid !== 1'b1 || player1_pos_x !== 10'(model_x(6)) || p1_tile !== 4'd6 ||
        active_player !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL qbox_bonus: got pv=%b x=%0d tile=%0d act=%b expected pv=1 x=%0d tile=6 act=0",
               pos_valid, player1_pos_x, p1_tile, active_player, model_x(6));
    end
    @(negedge clk);
    tests_run++;
    if (pos_valid !== 1'b0 || roll_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL qbox_wait: got pv=%b rdy=%b expected 0 0", pos_valid, roll_ready);
    end
    pulse_done();
    tests_run++;
    if (active_player !== 1'b1 || roll_ready !== 1'b1 || pos_valid !== 1'b0 || p1_tile !== 4'd6) begin
      tests_failed++;
      $display("[TB] FAIL qbox_handover: got act=%b rdy=%b pv=%b tile=%0d expected 1 1 0 6",
               active_player, roll_ready, pos_valid, p1_tile);
    end
  endtask

  task automatic test_goal();
    int bad;
    do_reset();
    quick_turn(1);
    quick_turn(6);
    quick_turn(1);
    quick_turn(1);
    quick_turn(1);
    offer_roll(6);
    tests_run++;
    if (p2_tile !== 4'(GOAL) || player2_pos_x !== 10'(model_x(GOAL)) || pos_valid !== 1'b1 ||
        active_player !== 1'b1 || player1_pos_x !== 10'(model_x(3))) begin
      tests_failed++;
      $display("[TB] FAIL goal_clamp: got tile=%0d x=%0d pv=%b act=%b p1x=%0d expected 9 560 1 1 200",
               p2_tile, player2_pos_x, pos_valid, active_player, player1_pos_x);
    end
    @(negedge clk);
    pulse_done();
    tests_run++;
    if (game_over !== 1'b1 || winner !== 1'b1 || roll_ready !== 1'b0 || pos_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL goal_finish: got over=%b win=%b rdy=%b pv=%b expected 1 1 0 0",
               game_over, winner, roll_ready, pos_valid);
    end
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      roll_valid = 1'b1;
      roll_value = 3'((i % 6) + 1);
      turn_done  = i[0];
      @(negedge clk);
      if (pos_valid !== 1'b0 || roll_ready !== 1'b0 || game_over !== 1'b1 ||
          p1_tile !== 4'd3 || p2_tile !== 4'(GOAL)) bad++;
    end
    roll_valid = 1'b0;
    turn_done  = 1'b0;
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL goal_terminal: got %0d cycles with activity expected 0", bad);
    end
  endtask

  task automatic test_ignored_inputs();
    do_reset();
    roll_valid = 1'b1;
    roll_value = 3'd0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (pos_valid !== 1'b0 || p1_tile !== 4'd0 || roll_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL illegal_roll0: got pv=%b tile=%0d rdy=%b expected 0 0 1",
               pos_valid, p1_tile, roll_ready);
    end
    roll_value = 3'd7;
    repeat (2) @(negedge clk);
    roll_valid = 1'b0;
    tests_run++;
    if (pos_valid !== 1'b0 || p1_tile !== 4'd0 || player1_pos_x !== 10'(TILE_X0)) begin
      tests_failed++;
      $display("[TB] FAIL illegal_roll7: got pv=%b tile=%0d x=%0d expected 0 0 20",
               pos_valid, p1_tile, player1_pos_x);
    end
    pulse_done();
    @(negedge clk);
    tests_run++;
    if (active_player !== 1'b0 || pos_valid !== 1'b0 || roll_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL done_in_idle: got act=%b pv=%b rdy=%b expected 0 0 1",
               active_player, pos_valid, roll_ready);
    end
    offer_roll(2);
    @(negedge clk);
    roll_valid = 1'b1;
    roll_value = 3'd5;
    repeat (3) @(negedge clk);
    roll_valid = 1'b0;
    tests_run++;
    if (pos_valid !== 1'b0 || p1_tile !== 4'd2 || player1_pos_x !== 10'(model_x(2)) ||
        roll_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL roll_in_wait: got pv=%b tile=%0d x=%0d rdy=%b expected 0 2 %0d 0",
               pos_valid, p1_tile, player1_pos_x, roll_ready, model_x(2));
    end
    pulse_done();
    @(negedge clk);
    tests_run++;
    if (active_player !== 1'b1 || pos_valid !== 1'b0 || p2_tile !== 4'd0 || p1_tile !== 4'd2) begin
      tests_failed++;
      $display("[TB] FAIL roll_not_queued: got act=%b pv=%b p2=%0d p1=%0d expected 1 0 0 2",
               active_player, pos_valid, p2_tile, p1_tile);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    offer_roll(1);
    repeat (T_OUT) @(negedge clk);
    pulse_done();
    tests_run++;
    if (active_player !== 1'b1 || timeout_err !== 1'b0 || roll_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL done_at_expiry: got act=%b terr=%b rdy=%b expected 1 0 1",
               active_player, timeout_err, roll_ready);
    end
    offer_roll(2);
    repeat (T_OUT) @(negedge clk);
    tests_run++;
    if (active_player !== 1'b1 || timeout_err !== 1'b0 || roll_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL timeout_early: got act=%b terr=%b rdy=%b expected 1 0 0",
               active_player, timeout_err, roll_ready);
    end
    @(negedge clk);
    tests_run++;
    if (active_player !== 1'b0 || timeout_err !== 1'b1 || roll_ready !== 1'b1 || p2_tile !== 4'd2) begin
      tests_failed++;
      $display("[TB] FAIL timeout_expire: got act=%b terr=%b rdy=%b p2=%0d expected 0 1 1 2",
               active_player, timeout_err, roll_ready, p2_tile);
    end
  endtask

  task automatic test_reset_mid_turn();
    offer_roll(3);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if ({p1_tile, p2_tile} !== 8'h00 || player1_pos_x !== 10'(TILE_X0) ||
        {pos_valid, active_player, roll_ready, game_over, timeout_err} !== 5'b00100) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_turn: got p1=%0d p2=%0d x=%0d flags=%b expected 0 0 20 00100",
               p1_tile, p2_tile, player1_pos_x,
               {pos_valid, active_player, roll_ready, game_over, timeout_err});
    end
    @(negedge clk);
    tests_run++;
    if (pos_valid !== 1'b0 || roll_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_no_pulse: got pv=%b rdy=%b expected 0 1", pos_valid, roll_ready);
    end
    model_reset();
  endtask

  task automatic test_random_games(input int games);
    int  v;
    int  d;
    int  k;
    bit  timed_out;
    bit  bonus;
    for (int g = 0; g < games; g++) begin
      do_reset();
      for (int turn = 0; turn < 200 && !m_over; turn++) begin
        v = $urandom_range(0, 7);
        offer_roll(v);
        if (v < 1 || v > 6) begin
          tests_run++;
          if (pos_valid !== 1'b0 || roll_ready !== 1'b1 ||
              p1_tile !== 4'(m_tile[0]) || p2_tile !== 4'(m_tile[1])) begin
            tests_failed++;
            $display("[TB] FAIL rand_illegal: got pv=%b rdy=%b p1=%0d p2=%0d expected 0 1 %0d %0d",
                     pos_valid, roll_ready, p1_tile, p2_tile, m_tile[0], m_tile[1]);
          end
          continue;
        end
        m_tile[m_active] = model_move(m_tile[m_active], v);
        bonus = 1'b0;
        forever begin
          tests_run++;
          if (pos_valid !== 1'b1 || active_player !== 1'(m_active) ||
              p1_tile !== 4'(m_tile[0]) || p2_tile !== 4'(m_tile[1]) ||
              player1_pos_x !== 10'(model_x(m_tile[0])) ||
              player2_pos_x !== 10'(model_x(m_tile[1]))) begin
            tests_failed++;
            $display("[TB] FAIL rand_move: got pv=%b act=%b tiles=%0d/%0d x=%0d/%0d expected 1 %0d %0d/%0d %0d/%0d",
                     pos_valid, active_player, p1_tile, p2_tile, player1_pos_x, player2_pos_x,
                     m_active, m_tile[0], m_tile[1], model_x(m_tile[0]), model_x(m_tile[1]));
          end
          d         = $urandom_range(0, 19);
          timed_out = (d > T_OUT - 1);
          k         = timed_out ? T_OUT - 1 : d;
          repeat (k + 1) @(negedge clk);
          if (!timed_out) turn_done = 1'b1;
          @(negedge clk);
          turn_done = 1'b0;
          if (timed_out) m_terr = 1'b1;
          if (m_tile[m_active] == GOAL) begin
            m_over   = 1'b1;
            m_winner = m_active;
            tests_run++;
            if (game_over !== 1'b1 || winner !== 1'(m_winner) || roll_ready !== 1'b0 ||
                timeout_err !== m_terr) begin
              tests_failed++;
              $display("[TB] FAIL rand_goal: got over=%b win=%b rdy=%b terr=%b expected 1 %0d 0 %b",
                       game_over, winner, roll_ready, timeout_err, m_winner, m_terr);
            end
            break;
          end
          if (!bonus && m_tile[m_active] == QBOX_TILE) begin
            m_tile[m_active] = model_move(m_tile[m_active], QBOX_BONUS);
            bonus = 1'b1;
            continue;
          end
          m_active = 1 - m_active;
          tests_run++;
          if (active_player !== 1'(m_active) || roll_ready !== 1'b1 || pos_valid !== 1'b0 ||
              timeout_err !== m_terr || game_over !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL rand_handover: got act=%b rdy=%b pv=%b terr=%b over=%b expected %0d 1 0 %b 0",
                     active_player, roll_ready, pos_valid, timeout_err, game_over, m_active, m_terr);
          end
          break;
        end
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    roll_valid = 1'b0;
    roll_value = 3'd0;
    turn_done  = 1'b0;
    model_reset();
    test_reset();
    test_basic_turn();
    test_qbox();
    test_goal();
    test_ignored_inputs();
    test_timeout();
    test_reset_mid_turn();
    test_random_games(12);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/turn_sequencer.md
# turn_sequencer

Turn scheduler for the two-player board game. It sits between the dice/input logic and `ui_render`. It accepts one dice roll per turn and computes the active player's target tile and x coordinate. It drives `pos_valid` and `active_player`, waits for `turn_done` from the renderer's player controller, and applies the question-box bonus move. It then passes the turn to the other player, or declares a winner at the goal tile.

## Interface
- `NUM_TILES`, 10: board tiles 0..NUM_TILES-1; goal tile G = NUM_TILES-1.
- `TILE_X0`, 20: x coordinate of tile 0.
- `TILE_W`, 60: x pitch per tile.
- `QBOX_TILE`, 4: question-box tile.
- `QBOX_BONUS`, 2: extra tiles granted on landing on QBOX_TILE.
- `DONE_TIMEOUT`, 4_000_000: max cycles to wait for `turn_done` (24-bit counter).

- `clk`, in, 1: system clock, the same clock as `ui_render`.
- `rst`, in, 1: synchronous, active-high reset.
- `roll_valid`, in, 1: roll offered.
- `roll_value`, in, 3: roll 1..6. Values 0 and 7 are illegal.
- `roll_ready`, out, 1: roll accepted this cycle if `roll_valid`.
- `turn_done`, in, 1: 1-cycle pulse from renderer; movement finished.
- `player1_pos_x`, out, 10: P1 target x.
- `player2_pos_x`, out, 10: P2 target x.
- `pos_valid`, out, 1: 1-cycle pulse; targets updated.
- `active_player`, out, 1: 0 = P1, 1 = P2.
- `p1_tile`, out, 4: P1 current tile index.
- `p2_tile`, out, 4: P2 current tile index.
- `game_over`, out, 1: sticky; the goal tile has been reached.
- `winner`, out, 1: winning player, valid while `game_over`.
- `timeout_err`, out, 1: sticky; a `turn_done` wait expired.

## Operation
- **State set:** IDLE, ISSUE, WAIT_DONE, BONUS, FINISH.
- **IDLE**
  - `roll_ready` = 1 only in IDLE.
  - Handshake is `roll_valid & roll_ready`. When it occurs with a legal value, the active player's new tile = min(tile + roll, G). That tile and its pos_x are registered, then go to ISSUE.
  - An illegal roll value is dropped; the block stays in IDLE.
- **ISSUE:** `pos_valid` = 1 for exactly this cycle. Clear the timeout counter, then go to WAIT_DONE.
- **WAIT_DONE:** the counter increments each cycle. On `turn_done`, or when the counter reaches DONE_TIMEOUT-1 (which also sets `timeout_err`), the movement is complete. Evaluate in priority order:
  1. Tile == G: go to FINISH, with `game_over` = 1 and `winner` = `active_player`.
  2. The move just completed was a roll move and tile == QBOX_TILE: tile = min(tile + QBOX_BONUS, G), update pos_x, go to BONUS.
  3. Otherwise toggle `active_player` and go to IDLE.
- **BONUS:** `pos_valid` = 1 for this cycle. Clear the counter, then go to WAIT_DONE with the bonus flag set. A bonus move never chains into another bonus.
- **FINISH:** terminal state. `roll_ready` = 0 and `pos_valid` = 0. Only `rst` exits it.
- **Coordinate arithmetic:** pos_x = TILE_X0 + tile*TILE_W, computed at ≥14 bits and truncated to 10. The default max is 20 + 9*60 = 560.
- Only the active player's `pos_x` changes. The other player's output holds.
- `turn_done` is ignored outside WAIT_DONE.
- `roll_valid` is ignored outside IDLE. Rolls are not queued.
- `turn_done` in the same cycle as timeout expiry counts as a normal done; `timeout_err` is not set.
- `active_player` is stable from roll acceptance until the turn ends.

## Timing
- **Reset values** (state after any cycle with `rst` = 1):
  - State IDLE, both tiles 0, both `pos_x` = TILE_X0 (20).
  - `pos_valid` 0, `active_player` 0, `roll_ready` 1.
  - `game_over` 0, `winner` 0, `timeout_err` 0.
- `rst` mid-turn aborts immediately. No `pos_valid` is issued in the following cycle.
- **Roll to issue:** roll accepted in cycle N; the new `pos_x` and tile are visible in N+1, and `pos_valid` = 1 in N+1. The renderer samples them together. WAIT_DONE starts at N+2.
- **Turn completion:** `turn_done` in cycle M.
  - Normal end: `active_player` toggles and `roll_ready` = 1 at M+1.
  - Bonus: new `pos_x` and `pos_valid` at M+1.
  - Goal: `game_over` = 1 at M+1.
- **Timeout:** after DONE_TIMEOUT cycles in WAIT_DONE without `turn_done`, the same transitions as completion apply on the next cycle.
- Minimum turn length is 3 cycles: accept, issue, done.
- All outputs are registered except `roll_ready` (decoded from state).

## Test plan
- **Reset:** drive `rst` for 2 cycles → all outputs at reset values; `player1_pos_x` = `player2_pos_x` = 20; `roll_ready` = 1.
- **Basic P1 turn:** P1 roll 3 → next cycle `player1_pos_x` = 200, `p1_tile` = 3, one `pos_valid` pulse. `turn_done` 5 cycles later → `active_player` = 1 the next cycle; `player2_pos_x` still 20.
- **Question box:** P1 at tile 0 rolls 4 → `pos_valid` with x = 260. After `turn_done`: a second `pos_valid` in the next cycle with x = 380 (tile 6). After the second `turn_done`, `active_player` toggles.
- **Goal:** P2 at tile 7 rolls 6 → tile clamped to 9, x = 560. After `turn_done`: `game_over` = 1, `winner` = 1. Further rolls are not accepted and no `pos_valid` is issued.
- **Illegal input and timing:**
  - `roll_value` 0 and 7 → no state change.
  - `roll_valid` during WAIT_DONE → ignored.
  - `turn_done` in IDLE → ignored.
- **Timeout and reset:**
  - With DONE_TIMEOUT = 16 and no `turn_done` → turn advances after 16 cycles and `timeout_err` = 1.
  - `rst` asserted during WAIT_DONE → reset values and IDLE next cycle.
